// File: rtl/adpcm_pkg.sv
// adpcm_pkg: IMA ADPCM step table, index adjust and decoder state encodings shared by encoder and decoder.
package adpcm_pkg;
  localparam logic [6:0] IDX_MAX = 7'd88;
  typedef enum logic [2:0] {IDLE, ACC2, ACC1, ACC0, UPD} dec_state_e;
  localparam logic [15:0] STEP_TBL [89] = '{
    16'd7, 16'd8, 16'd9, 16'd10, 16'd11, 16'd12, 16'd13, 16'd14, 16'd16, 16'd17,
    16'd19, 16'd21, 16'd23, 16'd25, 16'd28, 16'd31, 16'd34, 16'd37, 16'd41, 16'd45,
    16'd50, 16'd55, 16'd60, 16'd66, 16'd73, 16'd80, 16'd88, 16'd97, 16'd107, 16'd118,
    16'd130, 16'd143, 16'd157, 16'd173, 16'd190, 16'd209, 16'd230, 16'd253, 16'd279, 16'd307,
    16'd337, 16'd371, 16'd408, 16'd449, 16'd494, 16'd544, 16'd598, 16'd658, 16'd724, 16'd796,
    16'd876, 16'd963, 16'd1060, 16'd1166, 16'd1282, 16'd1411, 16'd1552, 16'd1707, 16'd1878, 16'd2066,
    16'd2272, 16'd2499, 16'd2749, 16'd3024, 16'd3327, 16'd3660, 16'd4026, 16'd4428, 16'd4871, 16'd5358,
    16'd5894, 16'd6484, 16'd7132, 16'd7845, 16'd8630, 16'd9493, 16'd10442, 16'd11487, 16'd12635, 16'd13899,
    16'd15289, 16'd16818, 16'd18500, 16'd20350, 16'd22385, 16'd24623, 16'd27086, 16'd29794, 16'd32767};
  function automatic logic [15:0] step_lookup(input logic [6:0] idx);
    return (idx > IDX_MAX) ? STEP_TBL[IDX_MAX] : STEP_TBL[idx];
  endfunction
  // magnitudes 0..3 give -1, 4..7 give 2,4,6,8
  function automatic logic signed [7:0] idx_adj(input logic [2:0] mag);
    return mag[2] ? $signed({5'b0, mag[1:0], 1'b0}) + 8'sd2 : -8'sd1;
  endfunction
endpackage

// File: rtl/adpcm_step_rom.sv
// adpcm_step_rom: combinational step-table lookup, index to 16-bit step size.
module adpcm_step_rom
  import adpcm_pkg::*;
(
  input  logic [6:0]  idx_i,
  output logic [15:0] step_o
);
  assign step_o = step_lookup(idx_i);
endmodule

// File: rtl/adpcm_pcm_decoder.sv
// adpcm_pcm_decoder: serial IMA ADPCM decoder, one 4-bit code in, one saturated 16-bit PCM sample out per 5 clocks.
module adpcm_pcm_decoder
  import adpcm_pkg::*;
#(
  parameter int PCM_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             block_enable,
  input  logic             code_valid,
  input  logic [3:0]       code_in,
  output logic             code_ready,
  output logic             pcm_valid,
  output logic [PCM_W-1:0] pcm_out
);
  dec_state_e         state_q;
  logic [3:0]         code_q;
  logic [15:0]        step_q, step_w;
  logic [16:0]        diff_q, add_d;
  logic signed [15:0] pred_q, pred_d;
  logic signed [17:0] sum_d;
  logic signed [7:0]  idx_sum_d;
  logic [6:0]         idx_q, idx_d;
  logic [PCM_W-1:0]   pcm_q;
  logic               valid_q;
  adpcm_step_rom u_rom (.idx_i(idx_q), .step_o(step_w));
  assign code_ready = (state_q == IDLE) && block_enable && !rst;
  assign pcm_valid  = valid_q;
  assign pcm_out    = pcm_q;
  always_comb begin
    add_d = state_q == ACC2 ? (code_q[2] ? {1'b0, step_q} : '0)
          : state_q == ACC1 ? (code_q[1] ? {2'b0, step_q[15:1]} : '0)
          : (code_q[0] ? {3'b0, step_q[15:2]} : '0);
    sum_d = code_q[3] ? {{2{pred_q[15]}}, pred_q} - {1'b0, diff_q}
                      : {{2{pred_q[15]}}, pred_q} + {1'b0, diff_q};
    pred_d = sum_d > 18'sd32767 ? 16'sh7fff : sum_d < -18'sd32768 ? 16'sh8000 : sum_d[15:0];
    idx_sum_d = $signed({1'b0, idx_q}) + idx_adj(code_q[2:0]);
    idx_d = idx_sum_d[7] ? '0 : idx_sum_d[6:0] > IDX_MAX ? IDX_MAX : idx_sum_d[6:0];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      code_q  <= '0;
      step_q  <= '0;
      diff_q  <= '0;
      pred_q  <= '0;
      idx_q   <= '0;
      pcm_q   <= '0;
      valid_q <= 1'b0;
    end else if (!block_enable) begin
      state_q <= IDLE;
      pred_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: if (code_valid) begin
          code_q  <= code_in;
          step_q  <= step_w;
          diff_q  <= {4'b0, step_w[15:3]};
          state_q <= ACC2;
        end
        ACC2: begin
          diff_q  <= diff_q + add_d;
          state_q <= ACC1;
        end
        ACC1: begin
          diff_q  <= diff_q + add_d;
          state_q <= ACC0;
        end
        ACC0: begin
          diff_q  <= diff_q + add_d;
          state_q <= UPD;
        end
        UPD: begin
          pred_q  <= pred_d;
          idx_q   <= idx_d;
          pcm_q   <= pred_d;
          valid_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adpcm_pcm_decoder.sv
// tb_adpcm_pcm_decoder: directed and random checks of the decoder against an arithmetic IMA reference model.
module tb_adpcm_pcm_decoder;
  logic        clk = 1'b0;
  logic        rst, block_enable, code_valid;
  logic [3:0]  code_in;
  logic        code_ready, pcm_valid;
  logic [15:0] pcm_out;
  int checks = 0;
  int errors = 0;
  int m_pred, m_idx;
  int step_tbl [89] = '{
    7, 8, 9, 10, 11, 12, 13, 14, 16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
    50, 55, 60, 66, 73, 80, 88, 97, 107, 118, 130, 143, 157, 173, 190, 209, 230, 253, 279, 307,
    337, 371, 408, 449, 494, 544, 598, 658, 724, 796, 876, 963, 1060, 1166, 1282, 1411, 1552, 1707, 1878, 2066,
    2272, 2499, 2749, 3024, 3327, 3660, 4026, 4428, 4871, 5358, 5894, 6484, 7132, 7845, 8630, 9493, 10442, 11487, 12635, 13899,
    15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794, 32767};
  int adj_tbl [8] = '{-1, -1, -1, -1, 2, 4, 6, 8};

  always #5 clk = ~clk;

  adpcm_pcm_decoder dut (
    .clk(clk), .rst(rst), .block_enable(block_enable), .code_valid(code_valid),
    .code_in(code_in), .code_ready(code_ready), .pcm_valid(pcm_valid), .pcm_out(pcm_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic logic [31:0] pcm32();
    return 32'($signed(pcm_out));
  endfunction

  task automatic model_step(input logic [3:0] c);
    int s, d;
    s = step_tbl[m_idx];
    d = s / 8;
    if (c[2]) d += s;
    if (c[1]) d += s / 2;
    if (c[0]) d += s / 4;
    m_pred = c[3] ? m_pred - d : m_pred + d;
    if (m_pred > 32767) m_pred = 32767;
    if (m_pred < -32768) m_pred = -32768;
    m_idx += adj_tbl[c[2:0]];
    if (m_idx < 0) m_idx = 0;
    if (m_idx > 88) m_idx = 88;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic decode(input logic [3:0] c);
    int n = 0;
    code_in = c;
    code_valid = 1'b1;
    while (!code_ready && n < 20) begin
      tick();
      n++;
    end
    chk("ready_wait", 32'(code_ready), 32'd1);
    tick();
    code_valid = 1'b0;
    model_step(c);
    repeat (4) begin
      chk("busy_ready", 32'(code_ready), 32'd0);
      chk("early_valid", 32'(pcm_valid), 32'd0);
      tick();
    end
    chk("strobe", 32'(pcm_valid), 32'd1);
    chk("pcm", pcm32(), 32'(m_pred));
    tick();
    chk("strobe_len", 32'(pcm_valid), 32'd0);
    chk("pcm_hold", pcm32(), 32'(m_pred));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_q[$];
    int acc_q[$];
    int accepts, strobes, busy, sv;
    logic [15:0] held;
    rst = 1'b1; block_enable = 1'b0; code_valid = 1'b0; code_in = '0;
    m_pred = 0; m_idx = 0;
    #2;
    chk("rst_pcm", pcm32(), 32'd0);
    chk("rst_valid", 32'(pcm_valid), 32'd0);
    chk("rst_ready", 32'(code_ready), 32'd0);
    #11 rst = 1'b0;
    tick();
    block_enable = 1'b1;
    // test 1: code 0 from reset, index clamps at 0
    decode(4'h0);
    chk("t1_zero", pcm32(), 32'd0);
    // test 2: known pair
    decode(4'h7);
    chk("t2_first", pcm32(), 32'd11);
    decode(4'hF);
    chk("t2_second", pcm32(), 32'hFFFF_FFED);
    // test 3: saturation both ways
    repeat (40) decode(4'h7);
    chk("t3_pos_sat", pcm32(), 32'd32767);
    repeat (40) decode(4'hF);
    chk("t3_neg_sat", pcm32(), 32'hFFFF_8000);
    // test 4: backpressure with code_valid held for 12 cycles
    accepts = 0; strobes = 0; busy = 0;
    code_in = 4'h3;
    for (int k = 0; k < 20; k++) begin
      code_valid = (k < 12);
      if (busy > 0) chk("t4_ready_busy", 32'(code_ready), 32'd0);
      if (pcm_valid) begin
        strobes++;
        if (exp_q.size() > 0) begin
          chk("t4_pcm", pcm32(), 32'(exp_q.pop_front()));
          chk("t4_latency", 32'(k - acc_q.pop_front()), 32'd5);
        end
      end
      if (code_ready && code_valid) begin
        model_step(code_in);
        exp_q.push_back(m_pred);
        acc_q.push_back(k);
        accepts++;
        busy = 4;
      end else if (busy > 0) busy--;
      tick();
    end
    code_valid = 1'b0;
    chk("t4_accepts", 32'(accepts), 32'd3);
    chk("t4_strobes", 32'(strobes), 32'd3);
    // random codes against the model
    repeat (60) decode(4'($urandom_range(0, 15)));
    // test 5: abort in ACC1
    code_in = 4'h5;
    code_valid = 1'b1;
    sv = 0;
    while (!code_ready && sv < 20) begin
      tick();
      sv++;
    end
    tick();
    code_valid = 1'b0;
    tick();
    block_enable = 1'b0;
    held = pcm_out;
    repeat (6) begin
      tick();
      chk("t5_no_strobe", 32'(pcm_valid), 32'd0);
      chk("t5_pcm_hold", 32'(pcm_out), 32'(held));
      chk("t5_ready_off", 32'(code_ready), 32'd0);
    end
    block_enable = 1'b1;
    m_pred = 0; m_idx = 0;
    decode(4'h0);
    chk("t5_zero", pcm32(), 32'd0);
    decode(4'h7);
    chk("t5_after", pcm32(), 32'd11);
    // test 6: async reset pulse between edges in ACC2
    code_in = 4'h6;
    code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("t6_pcm", pcm32(), 32'd0);
    chk("t6_valid", 32'(pcm_valid), 32'd0);
    chk("t6_ready", 32'(code_ready), 32'd0);
    #8 rst = 1'b0;
    tick();
    m_pred = 0; m_idx = 0;
    decode(4'h7);
    chk("t6_after", pcm32(), 32'd11);
    decode(4'hF);
    chk("t6_second", pcm32(), 32'hFFFF_FFED);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
